mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control FSM. It is the initiator side of the ALU interface: it sequences each instruction through fetch/decode/execute/memory/writeback, drives alu_control and the datapath mux selects, and consumes the ALU zero flag for beq. It sits between the instruction register and the datapath, and handshakes with a variable-latency memory via mem_ready.

Parameters:
RESET_TO_IDLE, 1, 1 = leave reset through a one-cycle IDLE state with all controls low; 0 = go straight to FETCH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
alu_control  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
alu_src_a  out  1  0 = PC, 1 = regA
alu_src_b  out  2  0 = regB, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
pc_en  out  1  PC write enable (branch condition already resolved)
i_or_d  out  1  0 = instruction address, 1 = data address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write
illegal  out  1  one-cycle pulse when an unsupported opcode or funct is detected
state_o  out  4  current state encoding, for debug

Behaviour:
- Moore outputs decoded from the state register. Exceptions: ir_write and pc_en in FETCH are ANDed with mem_ready; pc_en in BRANCH is set to zero.
- Default value of every control output in every state is 0. alu_control defaults to ADD.
- Reset: async assertion forces state = IDLE (or FETCH if RESET_TO_IDLE = 0). In IDLE all outputs are 0, alu_control = 0010, illegal = 0. Reset asserted mid-instruction aborts it; no partial write occurs after reset.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12.
- IDLE -> FETCH unconditionally.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, ADD, pc_source = 0.
  - Holds while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1, pc_en = 1, next state DECODE.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 3, ADD (branch target into ALUOut).
  - Dispatch by opcode: 000000 -> EXEC, 100011/101011 -> MEMADR, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX.
  - Any other opcode, or R-type with a funct outside {100100, 100101, 100000, 100010, 101010, 100111}: illegal = 1 for this cycle, next state FETCH, no state writes.
- MEMADR: alu_src_a = 1, alu_src_b = 2, ADD. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read = 1, i_or_d = 1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next state FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Holds until mem_ready, then FETCH. mem_write stays high for the whole wait.
- EXEC: alu_src_a = 1, alu_src_b = 0, alu_control = funct map (100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 101010 SLT, 100111 NOR). Next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, SUB, pc_source = 1, pc_en = zero. Next state FETCH.
- JUMP: pc_source = 2, pc_en = 1. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 2, ADD. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- Latency with mem_ready tied high, FETCH to the next FETCH: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- reg_write and mem_write are never both high. mem_read and mem_write are never both high.
- Unreachable state encodings go to FETCH and pulse illegal.

Decomposition:
- Package mips_ctrl_pkg holds: ALU_* and FUNCT_* codes, OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_J/OP_ADDI, state encodings, and alu_src_b/pc_source select constants.
- One combinational sub-module, alu_ctrl_decode: funct -> {alu_control, legal}. It is used by DECODE for the legality check and by EXEC for the ALU code.

Test Plan:
- Reset then R-type add: rst_n low, then high; opcode 000000, funct 100000, mem_ready = 1 -> states 0, 1, 2, 7, 8, 1. In state 7 alu_control = 0010. In state 8 reg_write = 1 and reg_dst = 1.
- lw with memory stall: opcode 100011, mem_ready low for 2 cycles in MEMRD -> MEMRD lasts 3 cycles with mem_read = 1 and i_or_d = 1, then MEMWB with reg_write = 1 and mem_to_reg = 1.
- beq both ways: opcode 000100, zero = 1 -> BRANCH has pc_en = 1, pc_source = 1, alu_control = 0110. Repeat with zero = 0 -> pc_en = 0. Both return to FETCH.
- Funct sweep: for each of the 6 legal functs, alu_control in EXEC equals the mapped code. Funct 000000 -> illegal pulses in DECODE, no EXEC, next state FETCH.
- Fetch stall: mem_ready = 0 for 4 cycles in FETCH -> ir_write = 0 and pc_en = 0 throughout; both go high in the single cycle mem_ready = 1.
- Reset mid-instruction: assert rst_n low during MEMWR -> mem_write drops to 0 asynchronously, before the next clock edge; after release the sequence restarts IDLE -> FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the multicycle MIPS controller.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Purpose  : Controller <-> datapath/memory signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_control, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal, state_o
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_decode
// Purpose  : R-type funct field to ALU operation code plus legality flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FUNCT_AND: alu_control = ALU_AND;
      FUNCT_OR:  alu_control = ALU_OR;
      FUNCT_ADD: alu_control = ALU_ADD;
      FUNCT_SUB: alu_control = ALU_SUB;
      FUNCT_SLT: alu_control = ALU_SLT;
      FUNCT_NOR: alu_control = ALU_NOR;
      default:   legal       = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multicycle MIPS control FSM driving the datapath selects.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit RESET_TO_IDLE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_ctrl_if.master        bus
);

  localparam state_t C_RESET_STATE = RESET_TO_IDLE ? S_IDLE : S_FETCH;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_funct_alu;
  logic       w_funct_legal;

  alu_ctrl_decode u_alu_dec (
    .funct       (bus.funct),
    .alu_control (w_funct_alu),
    .legal       (w_funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_RESET_STATE;
    else        r_state <= w_next;
  end

  assign bus.state_o = r_state;

  always_comb begin
    w_next          = r_state;
    bus.alu_control = ALU_ADD;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_REGB;
    bus.pc_source   = PCSRC_ALU;
    bus.pc_en       = 1'b0;
    bus.i_or_d      = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.illegal     = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target in ALUOut.
        bus.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE: begin
            if (w_funct_legal) w_next = S_EXEC;
            else begin
              bus.illegal = 1'b1;
              w_next      = S_FETCH;
            end
          end
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            bus.illegal = 1'b1;
            w_next      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next        = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = w_funct_alu;
        w_next          = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_source   = PCSRC_ALUOUT;
        bus.pc_en       = bus.zero;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_source = PCSRC_JUMP;
        bus.pc_en     = 1'b1;
        w_next        = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next        = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        w_next        = S_FETCH;
      end
      default: begin
        bus.illegal = 1'b1;
        w_next      = S_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Random instruction stream against a phase-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                 P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9,
                 P_JUMP = 10, P_ADDIEX = 11, P_ADDIWB = 12;
  localparam int N_CYCLES = 4000;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.RESET_TO_IDLE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h required %0h", tag, $time, got, exp);
  endtask

  logic [5:0] legal_funct [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111};
  logic [3:0] funct_code  [6] = '{4'b0000,   4'b0001,   4'b0010,   4'b0110,   4'b0111,   4'b1100};

  function automatic int funct_index(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (legal_funct[i] == f) return i;
    return -1;
  endfunction

  // Reference model: current instruction as a list of phases.
  int         path [$];
  int         idx;
  int         cur;
  logic [5:0] op, fn;
  logic       ill;
  logic       mr, z;
  int         n_wr_rst;

  task automatic start_instr();
    int k;
    k    = $urandom_range(0, 7);
    path = '{P_FETCH, P_DECODE};
    ill  = 1'b0;
    fn   = 6'($urandom_range(0, 63));
    case (k)
      0: begin
        op = 6'b000000;
        fn = legal_funct[$urandom_range(0, 5)];
        path.push_back(P_EXEC); path.push_back(P_ALUWB);
      end
      1: begin op = 6'b100011; path.push_back(P_MEMADR); path.push_back(P_MEMRD); path.push_back(P_MEMWB); end
      2: begin op = 6'b101011; path.push_back(P_MEMADR); path.push_back(P_MEMWR); end
      3: begin op = 6'b000100; path.push_back(P_BRANCH); end
      4: begin op = 6'b000010; path.push_back(P_JUMP); end
      5: begin op = 6'b001000; path.push_back(P_ADDIEX); path.push_back(P_ADDIWB); end
      6: begin
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
        ill = 1'b1;
      end
      default: begin
        op = 6'b000000;
        if ($urandom_range(0, 1) == 0) fn = 6'b000000;
        else while (funct_index(fn) >= 0) fn = 6'($urandom_range(0, 63));
        ill = 1'b1;
      end
    endcase
    idx = 0;
    cur = P_FETCH;
  endtask

  function automatic ctrl_t exp_ctrl(input int ph, input logic r, input logic zz,
                                     input logic [5:0] f, input logic il);
    ctrl_t e;
    e     = '0;
    e.alu = 4'b0010;
    case (ph)
      P_FETCH:  begin e.mem_read = 1; e.src_b = 2'd1; e.ir_write = r; e.pc_en = r; end
      P_DECODE: begin e.src_b = 2'd3; e.illegal = il; end
      P_MEMADR: begin e.src_a = 1; e.src_b = 2'd2; end
      P_MEMRD:  begin e.mem_read = 1; e.i_or_d = 1; end
      P_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      P_MEMWR:  begin e.mem_write = 1; e.i_or_d = 1; end
      P_EXEC:   begin e.src_a = 1; e.alu = funct_code[funct_index(f)]; end
      P_ALUWB:  begin e.reg_write = 1; e.reg_dst = 1; end
      P_BRANCH: begin e.src_a = 1; e.alu = 4'b0110; e.pc_src = 2'd1; e.pc_en = zz; end
      P_JUMP:   begin e.pc_src = 2'd2; e.pc_en = 1; end
      P_ADDIEX: begin e.src_a = 1; e.src_b = 2'd2; end
      P_ADDIWB: begin e.reg_write = 1; end
      default:  ;
    endcase
    return e;
  endfunction

  function automatic ctrl_t obs();
    ctrl_t o;
    o.alu        = bus.alu_control;
    o.src_a      = bus.alu_src_a;
    o.src_b      = bus.alu_src_b;
    o.pc_src     = bus.pc_source;
    o.pc_en      = bus.pc_en;
    o.i_or_d     = bus.i_or_d;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  task automatic drive_inputs();
    mr = ($urandom_range(0, 9) < 6);
    z  = 1'($urandom_range(0, 1));
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
  endtask

  initial begin
    bit inject;
    op = '0; fn = '0; ill = 1'b0; mr = 1'b0; z = 1'b0;
    idx = 0; n_wr_rst = 0;
    path.delete();
    cur = P_IDLE;
    drive_inputs();
    @(posedge clk); #4;
    check("reset_state", 32'(bus.state_o), 32'(P_IDLE));
    check("reset_ctrl", 32'(obs()), 32'(exp_ctrl(P_IDLE, mr, z, fn, 1'b0)));
    rst_n = 1'b1;
    #1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      check($sformatf("state[ph%0d]", cur), 32'(bus.state_o), 32'(cur));
      check($sformatf("ctrl[ph%0d]", cur), 32'(obs()), 32'(exp_ctrl(cur, mr, z, fn, ill)));

      if (cur == P_IDLE) start_instr();
      else if ((cur == P_FETCH || cur == P_MEMRD || cur == P_MEMWR) && !mr) ;
      else begin
        idx++;
        if (idx >= path.size()) start_instr();
        else cur = path[idx];
      end

      @(posedge clk); #1;
      drive_inputs();
      inject = (cur == P_MEMWR && n_wr_rst < 4 && $urandom_range(0, 1) == 1) ||
               ($urandom_range(0, 299) == 0);
      if (inject) begin
        if (cur == P_MEMWR) n_wr_rst++;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state_o), 32'(P_IDLE));
        check("async_rst_ctrl", 32'(obs()), 32'(exp_ctrl(P_IDLE, mr, z, fn, 1'b0)));
        cur = P_IDLE;
        idx = 0;
        path.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
      end else begin
        #4;
      end
    end

    check("memwr_reset_seen", 32'(n_wr_rst > 0), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
